// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one unified instruction/data memory port between two
//            requesters (M0 = multicycle core, M1 = loader/debug DMA).
//            The winning request is registered and then driven onto the
//            memory for a fixed read latency. The owner then gets a one-cycle
//            ready pulse together with its registered read data.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW      address width (byte address, passed through unchanged)
//   DW      data width
//   RD_LAT  memory read latency in cycles, legal range 0..7
//           (0 = combinational read, mem_rd valid with mem_adr)
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   m0_req/we/adr/wd           M0 request; held stable until m0_ready
//   m0_ready, m0_rd            M0 one-cycle completion pulse, read data
//   m1_*                       same as M0, for M1
//   mem_we/adr/wd, mem_rd      shared memory port
//   gnt                        one-hot owner (bit0 = M0, bit1 = M1), 0 idle
//   busy                       high in ACCESS or DONE
// Configuration
//   MEM_ARB_FIXED_PRIO_EN      when defined, M0 wins every tie and no
//                              round-robin history is kept; otherwise ties
//                              alternate between the two requesters.
// ============================================================================
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  // M0: core port
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rd,
  // M1: loader / debug DMA port
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rd,
  // Shared memory port
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  // Status
  output logic [1:0]    gnt,
  output logic          busy
);

  // The countdown register is 3 bits wide, which covers RD_LAT 0..7.
  localparam logic [2:0] c_rd_lat = 3'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [1:0]      r_gnt;
  logic            r_we_q;
  logic [AW-1:0]   r_mem_adr;
  logic [DW-1:0]   r_mem_wd;
  logic [2:0]      r_cnt;
  logic [DW-1:0]   r_m0_rd;
  logic [DW-1:0]   r_m1_rd;

  logic            w_any_req;
  logic            w_win_m1;     // 1: M1 wins the current IDLE arbitration
  logic            w_take;       // grant accepted this cycle
  logic            w_capture;    // last ACCESS cycle of a read
  logic            w_mem_we;
  logic            w_busy;
  logic            w_m0_ready;
  logic            w_m1_ready;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_FIXED_PRIO_EN
  // M1 is served only when M0 is not asking.
  always_comb begin
    w_any_req = m0_req | m1_req;
    w_win_m1  = ~m0_req;
  end
`else
  // r_last remembers the previous owner (1 = M1). Out of reset it points at
  // M1 so that M0 wins the first tie.
  logic r_last;

  always_comb begin
    w_any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
      w_win_m1 = ~r_last;
    end else begin
      w_win_m1 = ~m0_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_win_m1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_capture    = 1'b0;
    w_mem_we     = 1'b0;
    w_busy       = 1'b0;
    w_m0_ready   = 1'b0;
    w_m1_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_take       = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_busy   = 1'b1;
        // A write occupies exactly one ACCESS cycle.
        w_mem_we = r_we_q;
        if (r_we_q || (r_cnt == 3'd0)) begin
          w_capture    = ~r_we_q;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_m0_ready   = r_gnt[0];
        w_m1_ready   = r_gnt[1];
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: registered request, latency counter, read-data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt     <= 2'b00;
      r_we_q    <= 1'b0;
      r_mem_adr <= '0;
      r_mem_wd  <= '0;
      r_cnt     <= 3'd0;
      r_m0_rd   <= '0;
      r_m1_rd   <= '0;
    end else begin
      if (w_take) begin
        r_gnt     <= w_win_m1 ? 2'b10 : 2'b01;
        r_we_q    <= w_win_m1 ? m1_we  : m0_we;
        r_mem_adr <= w_win_m1 ? m1_adr : m0_adr;
        r_mem_wd  <= w_win_m1 ? m1_wd  : m0_wd;
        r_cnt     <= c_rd_lat;
      end else if (r_state == S_DONE) begin
        r_gnt <= 2'b00;
      end

      if ((r_state == S_ACCESS) && !r_we_q && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end

      // Only the owner's read register is touched; the other side keeps
      // whatever it last captured.
      if (w_capture) begin
        if (r_gnt[1]) begin
          r_m1_rd <= mem_rd;
        end else begin
          r_m0_rd <= mem_rd;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign mem_we   = w_mem_we;
  assign mem_adr  = r_mem_adr;
  assign mem_wd   = r_mem_wd;
  assign gnt      = r_gnt;
  assign busy     = w_busy;
  assign m0_ready = w_m0_ready;
  assign m1_ready = w_m1_ready;
  assign m0_rd    = r_m0_rd;
  assign m1_rd    = r_m1_rd;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Two instances are built,
//            one with RD_LAT=0 and one with RD_LAT=3; `sel` routes requests
//            to one of them and observes its outputs. Expected behaviour is
//            derived per transaction from the request time, owner and
//            latency. The memory model returns data that depends on the
//            address and on a per-cycle salt, so the capture cycle is
//            observable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        sel;          // 0: RD_LAT=0 instance, 1: RD_LAT=3 instance
  logic [31:0] salt;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_adr, m0_wd, m1_adr, m1_wd;

  logic        d0_m0_req, d0_m1_req, d3_m0_req, d3_m1_req;
  logic        d0_m0_ready, d0_m1_ready, d3_m0_ready, d3_m1_ready;
  logic [31:0] d0_m0_rd, d0_m1_rd, d3_m0_rd, d3_m1_rd;
  logic        d0_mem_we, d3_mem_we;
  logic [31:0] d0_mem_adr, d0_mem_wd, d0_mem_rd;
  logic [31:0] d3_mem_adr, d3_mem_wd, d3_mem_rd;
  logic [1:0]  d0_gnt, d3_gnt;
  logic        d0_busy, d3_busy;

  logic        o_m0_ready, o_m1_ready, o_mem_we, o_busy;
  logic [31:0] o_m0_rd, o_m1_rd, o_mem_adr, o_mem_wd;
  logic [1:0]  o_gnt;

  int          checks;
  int          errors;

  // Reference state: previous owner per instance and expected rd registers.
  int          last_m [2];
  logic [31:0] exp_rd [2][2];

  function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic [31:0] s);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a ^ {s[15:0], s[31:16]}) + s;
  endfunction

  assign d0_m0_req = m0_req & ~sel;
  assign d0_m1_req = m1_req & ~sel;
  assign d3_m0_req = m0_req & sel;
  assign d3_m1_req = m1_req & sel;
  assign d0_mem_rd = mem_fn(d0_mem_adr, salt);
  assign d3_mem_rd = mem_fn(d3_mem_adr, salt);

  assign o_m0_ready = sel ? d3_m0_ready : d0_m0_ready;
  assign o_m1_ready = sel ? d3_m1_ready : d0_m1_ready;
  assign o_m0_rd    = sel ? d3_m0_rd    : d0_m0_rd;
  assign o_m1_rd    = sel ? d3_m1_rd    : d0_m1_rd;
  assign o_mem_we   = sel ? d3_mem_we   : d0_mem_we;
  assign o_mem_adr  = sel ? d3_mem_adr  : d0_mem_adr;
  assign o_mem_wd   = sel ? d3_mem_wd   : d0_mem_wd;
  assign o_gnt      = sel ? d3_gnt      : d0_gnt;
  assign o_busy     = sel ? d3_busy     : d0_busy;

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .m0_req(d0_m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wd(m0_wd),
    .m0_ready(d0_m0_ready), .m0_rd(d0_m0_rd),
    .m1_req(d0_m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wd(m1_wd),
    .m1_ready(d0_m1_ready), .m1_rd(d0_m1_rd),
    .mem_we(d0_mem_we), .mem_adr(d0_mem_adr), .mem_wd(d0_mem_wd),
    .mem_rd(d0_mem_rd), .gnt(d0_gnt), .busy(d0_busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .m0_req(d3_m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wd(m0_wd),
    .m0_ready(d3_m0_ready), .m0_rd(d3_m0_rd),
    .m1_req(d3_m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wd(m1_wd),
    .m1_ready(d3_m1_ready), .m1_rd(d3_m1_rd),
    .mem_we(d3_mem_we), .mem_adr(d3_mem_adr), .mem_wd(d3_mem_wd),
    .mem_rd(d3_mem_rd), .gnt(d3_gnt), .busy(d3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (sel=%0d)", tag, obs, exp, sel);
    end
  endtask

  task automatic reset_model();
    last_m[0] = 1; last_m[1] = 1;
    exp_rd[0][0] = '0; exp_rd[0][1] = '0;
    exp_rd[1][0] = '0; exp_rd[1][1] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    reset_model();
  endtask

  task automatic chk_rds(input string tag);
    chk({tag, "_m0_rd"}, o_m0_rd, exp_rd[sel][0]);
    chk({tag, "_m1_rd"}, o_m1_rd, exp_rd[sel][1]);
  endtask

  // One arbitration round starting in an IDLE cycle. Returns the expected
  // winner (-1 if nobody requested) and leaves time just after the edge
  // into the IDLE cycle following DONE, with the winner's req dropped.
  task automatic txn(input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] dv0,
                     input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] dv1,
                     input bit chg, output int win);
    int          dur;
    logic        wwe;
    logic [31:0] wa, wd;
    m0_req = q0; m0_we = w0; m0_adr = a0; m0_wd = dv0;
    m1_req = q1; m1_we = w1; m1_adr = a1; m1_wd = dv1;
    salt = $urandom;
    win = -1;
    if (q0 && q1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win = (last_m[sel] == 1) ? 0 : 1;
`endif
    end else if (q0) begin
      win = 0;
    end else if (q1) begin
      win = 1;
    end
    @(negedge clk);
    chk("idle_gnt", {30'd0, o_gnt}, 32'd0);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_ready", {30'd0, o_m1_ready, o_m0_ready}, 32'd0);
    chk("idle_mem_we", {31'd0, o_mem_we}, 32'd0);
    if (win < 0) begin
      @(posedge clk); #1;
      return;
    end
    last_m[sel] = win;
    wwe = (win == 1) ? w1 : w0;
    wa  = (win == 1) ? a1 : a0;
    wd  = (win == 1) ? dv1 : dv0;
    dur = wwe ? 1 : ((sel ? 3 : 0) + 1);
    for (int c = 1; c <= dur; c++) begin
      @(posedge clk); #1;
      salt = $urandom;
      // Inputs moving during ACCESS must not reach the memory port.
      if (chg && c == 1) begin
        if (win == 1) m1_adr = a1 ^ 32'hE0; else m0_adr = a0 ^ 32'hE0;
      end
      @(negedge clk);
      chk("acc_gnt", {30'd0, o_gnt}, (win == 1) ? 32'd2 : 32'd1);
      chk("acc_busy", {31'd0, o_busy}, 32'd1);
      chk("acc_mem_we", {31'd0, o_mem_we}, {31'd0, wwe});
      chk("acc_mem_adr", o_mem_adr, wa);
      chk("acc_mem_wd", o_mem_wd, wd);
      chk("acc_ready", {30'd0, o_m1_ready, o_m0_ready}, 32'd0);
      chk_rds("acc");
      if (c == dur && !wwe) exp_rd[sel][win] = mem_fn(wa, salt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_gnt", {30'd0, o_gnt}, (win == 1) ? 32'd2 : 32'd1);
    chk("done_busy", {31'd0, o_busy}, 32'd1);
    chk("done_mem_we", {31'd0, o_mem_we}, 32'd0);
    chk("done_ready", {30'd0, o_m1_ready, o_m0_ready}, (win == 1) ? 32'd2 : 32'd1);
    chk_rds("done");
    @(posedge clk); #1;
    if (win == 1) m1_req = 1'b0; else m0_req = 1'b0;
    m0_adr = a0; m1_adr = a1;
  endtask

  // Random traffic: each side keeps its pending request stable until served,
  // and a side that was just served stays quiet for one IDLE cycle.
  task automatic rand_phase(input int n);
    logic        pq [2];
    logic        pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    int          cool;
    int          w;
    cool = -1;
    for (int m = 0; m < 2; m++) begin
      pq[m] = 1'b0; pw[m] = 1'b0; pa[m] = '0; pd[m] = '0;
    end
    for (int i = 0; i < n; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pq[m] && cool != m && $urandom_range(3) != 0) begin
          pq[m] = 1'b1;
          pw[m] = 1'($urandom_range(1));
          pa[m] = $urandom;
          pd[m] = $urandom;
        end
      end
      txn(pq[0], pw[0], pa[0], pd[0], pq[1], pw[1], pa[1], pd[1],
          bit'($urandom_range(1)), w);
      if (w >= 0) pq[w] = 1'b0;
      cool = w;
    end
  endtask

  initial begin
    int          w;
    int          nxt;
    logic        fw [2];
    logic [31:0] fa [2];
    logic [31:0] fd [2];
    checks = 0; errors = 0;
    reset = 1'b1; sel = 1'b0; salt = '0;
    m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wd = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wd = '0;
    reset_model();
    do_reset();

    // Reset values of both instances
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clk);
      chk("rst_gnt", {30'd0, o_gnt}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
      chk("rst_ready", {30'd0, o_m1_ready, o_m0_ready}, 32'd0);
      chk("rst_mem_adr", o_mem_adr, 32'd0);
      chk("rst_mem_wd", o_mem_wd, 32'd0);
      chk("rst_m0_rd", o_m0_rd, 32'd0);
      chk("rst_m1_rd", o_m1_rd, 32'd0);
      @(posedge clk); #1;
    end

    // RD_LAT=0: M0 read of 0x100, M1 write of 0x20
    sel = 1'b0;
    txn(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, w);
    chk("t1_win", 32'(w), 32'd0);
    chk("t1_m0_rd", o_m0_rd, 32'hDEADBEEF);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, w);
    chk("t2_win", 32'(w), 32'd1);
    chk("t2_m1_rd", o_m1_rd, 32'd0);

    // Tie after an M0 transaction and an idle cycle
    txn(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, w);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, w);
    txn(1'b1, 1'b0, 32'h304, 32'h0, 1'b1, 1'b0, 32'h308, 32'h0, 1'b0, w);
`ifdef MEM_ARB_FIXED_PRIO_EN
    chk("tie_win", 32'(w), 32'd0);
`else
    chk("tie_win", 32'(w), 32'd1);
`endif

    // Both requesting, each quiet for one cycle after its ready
    do_reset();
    for (int m = 0; m < 2; m++) begin
      fw[m] = 1'($urandom_range(1)); fa[m] = $urandom; fd[m] = $urandom;
    end
    txn(1'b1, fw[0], fa[0], fd[0], 1'b1, fw[1], fa[1], fd[1], 1'b0, w);
    chk("t3_order0", 32'(w), 32'd0);
    for (int k = 1; k < 6; k++) begin
      fw[w] = 1'($urandom_range(1)); fa[w] = $urandom; fd[w] = $urandom;
      nxt = 1 - w;
      txn(nxt == 0, fw[0], fa[0], fd[0], nxt == 1, fw[1], fa[1], fd[1], 1'b0, w);
      chk("t3_order", 32'(w), 32'(k % 2));
    end

    // RD_LAT=3: M0 read of 0x40, then M1 read of 0x60 with adr moving to 0x80
    sel = 1'b1;
    txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, w);
    chk("t4_win", 32'(w), 32'd0);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0, 1'b1, w);
    chk("t6_m1_rd", o_m1_rd, exp_rd[1][1]);

    rand_phase(120);
    sel = 1'b0;
    rand_phase(120);

    // Reset during the 2nd ACCESS cycle of an RD_LAT=3 read
    sel = 1'b1;
    txn(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, w);
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h48; m1_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_acc1_busy", {31'd0, o_busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_acc2_gnt", {30'd0, o_gnt}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; m0_req = 1'b0;
    reset_model();
    @(negedge clk);
    chk("t5_gnt", {30'd0, o_gnt}, 32'd0);
    chk("t5_busy", {31'd0, o_busy}, 32'd0);
    chk("t5_mem_we", {31'd0, o_mem_we}, 32'd0);
    chk("t5_m0_rd", o_m0_rd, 32'd0);
    chk("t5_mem_adr", o_mem_adr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("t5_no_ready", {31'd0, o_m0_ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b1, 32'h54, 32'h9, 1'b0, w);
    chk("t5_tie_m0", 32'(w), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
